// File: rtl/laser_host.sv
// Host-side driver and scorer for the two-circle laser coverage engine.
// Buffers a 40-point frame, streams it to the engine, then scores the returned circles.
module laser_host #(
    parameter int NPTS    = 40,
    parameter int R2      = 16,
    parameter int TIMEOUT = 20000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_x,
    input  logic [3:0]  in_y,
    output logic        LRST,
    output logic [3:0]  X,
    output logic [3:0]  Y,
    input  logic        DONE,
    input  logic [3:0]  C1X,
    input  logic [3:0]  C1Y,
    input  logic [3:0]  C2X,
    input  logic [3:0]  C2Y,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_c1,
    output logic [7:0]  res_c2,
    output logic [5:0]  res_score,
    output logic [15:0] res_cycles,
    output logic        res_timeout
);
    localparam int IW = $clog2(NPTS);
    localparam logic [IW-1:0] LAST    = IW'(NPTS - 1);
    localparam logic [15:0]   TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_STREAM,
        ST_WAIT,
        ST_SCORE,
        ST_REPORT
    } state_t;

    state_t        state_q;
    logic [7:0]    buf_q [NPTS];
    logic [IW-1:0] idx_q;
    logic [15:0]   wait_q;
    logic [5:0]    acc_q;
    logic          lrst_q;
    logic [3:0]    x_q, y_q;
    logic          rv_q, to_q;
    logic [7:0]    c1_q, c2_q;
    logic [5:0]    score_q;
    logic [15:0]   cycles_q;

    logic [IW-1:0] rd_idx_d;
    logic [7:0]    pt_d;
    logic          hit_d;
    logic          load_fire_d;

    function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                       input logic [3:0] cx, input logic [3:0] cy);
        logic [3:0] dx, dy;
        logic [7:0] sx, sy;
        logic [8:0] d2;
        dx = (px >= cx) ? px - cx : cx - px;
        dy = (py >= cy) ? py - cy : cy - py;
        sx = {4'd0, dx} * {4'd0, dx};
        sy = {4'd0, dy} * {4'd0, dy};
        d2 = {1'b0, sx} + {1'b0, sy};
        return d2 <= 9'(R2);
    endfunction

    // One read port serves streaming (look one point ahead) and scoring.
    always_comb begin
        load_fire_d = (state_q == ST_LOAD) && in_valid;
        rd_idx_d    = idx_q;
        if (state_q == ST_LOAD)
            rd_idx_d = '0;
        else if (state_q == ST_STREAM && idx_q != LAST)
            rd_idx_d = idx_q + IW'(1);
        pt_d  = buf_q[rd_idx_d];
        hit_d = in_circle(pt_d[7:4], pt_d[3:0], c1_q[7:4], c1_q[3:0]) ||
                in_circle(pt_d[7:4], pt_d[3:0], c2_q[7:4], c2_q[3:0]);
    end

    always_ff @(posedge CLK) begin
        if (load_fire_d)
            buf_q[idx_q] <= {in_x, in_y};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_LOAD;
            idx_q    <= '0;
            wait_q   <= '0;
            acc_q    <= '0;
            lrst_q   <= 1'b1;
            x_q      <= '0;
            y_q      <= '0;
            rv_q     <= 1'b0;
            to_q     <= 1'b0;
            c1_q     <= '0;
            c2_q     <= '0;
            score_q  <= '0;
            cycles_q <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (in_valid) begin
                        if (idx_q == LAST) begin
                            state_q <= ST_STREAM;
                            idx_q   <= '0;
                            lrst_q  <= 1'b0;
                            x_q     <= pt_d[7:4];
                            y_q     <= pt_d[3:0];
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                ST_STREAM: begin
                    if (idx_q == LAST) begin
                        state_q <= ST_WAIT;
                        idx_q   <= '0;
                        x_q     <= '0;
                        y_q     <= '0;
                        wait_q  <= '0;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                        x_q   <= pt_d[7:4];
                        y_q   <= pt_d[3:0];
                    end
                end
                ST_WAIT: begin
                    // DONE takes priority over a timeout landing on the same cycle.
                    if (DONE) begin
                        c1_q     <= {C1X, C1Y};
                        c2_q     <= {C2X, C2Y};
                        cycles_q <= wait_q;
                        lrst_q   <= 1'b1;
                        acc_q    <= '0;
                        idx_q    <= '0;
                        state_q  <= ST_SCORE;
                    end else if (wait_q == TO_LAST) begin
                        lrst_q   <= 1'b1;
                        to_q     <= 1'b1;
                        score_q  <= '0;
                        c1_q     <= '0;
                        c2_q     <= '0;
                        cycles_q <= 16'(TIMEOUT);
                        rv_q     <= 1'b1;
                        state_q  <= ST_REPORT;
                    end else if (wait_q != 16'hFFFF) begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                ST_SCORE: begin
                    acc_q <= acc_q + {5'd0, hit_d};
                    if (idx_q == LAST) begin
                        score_q <= acc_q + {5'd0, hit_d};
                        rv_q    <= 1'b1;
                        idx_q   <= '0;
                        state_q <= ST_REPORT;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        rv_q    <= 1'b0;
                        to_q    <= 1'b0;
                        idx_q   <= '0;
                        state_q <= ST_LOAD;
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign in_ready    = (state_q == ST_LOAD);
    assign LRST        = lrst_q;
    assign X           = x_q;
    assign Y           = y_q;
    assign res_valid   = rv_q;
    assign res_c1      = c1_q;
    assign res_c2      = c2_q;
    assign res_score   = score_q;
    assign res_cycles  = cycles_q;
    assign res_timeout = to_q;

endmodule

// File: doc/laser_host.md
Name: laser_host

Overview:
- Host-side driver and scorer for the two-circle laser coverage engine.
- Accepts a 40-point frame from an upstream source over a valid/ready handshake and buffers it.
- Holds the engine in reset until the frame is complete, then streams one point per cycle on X/Y and waits for DONE.
- Captures C1/C2, counts how many of the 40 points the two circles cover, and reports score, latency and timeout status downstream.

Parameters:
NPTS, 40, points per frame; fixed by the engine protocol.
R2, 16, covered iff dx*dx + dy*dy <= R2 (dx, dy absolute 4-bit differences).
TIMEOUT, 20000, maximum WAIT cycles without DONE before the frame is aborted.

Ports:
CLK  input  1  clock
RST  input  1  reset
in_valid  input  1  upstream point valid
in_x  input  4  upstream point X
in_y  input  4  upstream point Y
in_ready  output  1  high only in LOAD; a point transfers when in_valid && in_ready
LRST  output  1  registered reset to the engine, active-high
X  output  4  registered point X to the engine
Y  output  4  registered point Y to the engine
DONE  input  1  engine completion pulse
C1X, C1Y, C2X, C2Y  input  4 each  engine circle centres; sampled when DONE=1
res_valid  output  1  result valid
res_ready  input  1  downstream accept
res_c1  output  8  {C1X,C1Y} captured
res_c2  output  8  {C2X,C2Y} captured
res_score  output  6  covered point count, 0..40
res_cycles  output  16  WAIT cycles before DONE, saturating
res_timeout  output  1  frame aborted by timeout

Behaviour:
- Reset: RST is asynchronous and active-high; clock is CLK.
- Reset values: state=LOAD, LRST=1, X=Y=0, res_valid=0, all res_* fields=0, load/stream/score counters=0.
- Reset mid-operation discards any partial frame or result. LRST is asserted immediately on RST.
- States: LOAD -> STREAM -> WAIT -> SCORE -> REPORT -> LOAD. WAIT goes directly to REPORT on timeout.
- LOAD:
  - LRST=1; in_ready=1.
  - Each transfer writes buf[k], k=0..39.
  - The edge that accepts the 40th point (k=39) moves to STREAM, clears LRST and registers X/Y=buf[0] on that same edge.
  - in_ready is low in every other state; upstream must hold its data.
- STREAM:
  - 40 cycles, s=0..39; during cycle s, X/Y=buf[s].
  - The engine samples one point on each of the 40 edges that follow LRST release.
  - The edge ending s=39 enters WAIT, sets X=Y=0 and clears the wait counter.
- WAIT:
  - wait counter increments each cycle with DONE=0, saturating at 0xFFFF.
  - DONE=1: capture C1X/C1Y/C2X/C2Y; res_cycles := wait counter (0 if DONE arrives in the first WAIT cycle); LRST:=1 on that edge; enter SCORE.
  - LRST held high stops the engine from re-entering input on the next cycle.
  - Timeout: the counter reaches TIMEOUT with DONE=0 -> LRST:=1, res_timeout:=1, res_score:=0, res_c1=res_c2=0, res_cycles:=TIMEOUT; enter REPORT.
  - DONE and timeout on the same cycle: DONE wins.
- SCORE:
  - 40 cycles, one point per cycle, i=0..39.
  - covered_i = (dx1^2+dy1^2 <= R2) || (dx2^2+dy2^2 <= R2).
  - Squares use 8-bit unsigned arithmetic and the sum is 9 bits; no overflow.
  - Equivalent rule at R2=16: Manhattan <= 4, plus offsets (2,3) and (3,2).
  - The accumulator is 6 bits; the edge ending i=39 loads res_score and enters REPORT.
  - Latency: res_valid rises 40 edges after the edge that sampled DONE.
- REPORT:
  - res_valid=1, all res_* held stable until res_valid && res_ready.
  - On that edge: res_valid:=0, res_timeout:=0, enter LOAD; in_ready is high on the next cycle.
- DONE while in LOAD, STREAM, SCORE or REPORT is ignored.
- The frame buffer is untouched outside LOAD.

Test Plan:
- Reset -> LRST=1, in_ready=1, res_valid=0, X=Y=0; in_valid toggling during RST accepts nothing.
- Load points (i mod 16, i/16), i=0..39, with in_valid low every 3rd cycle -> exactly 40 accepted, in_ready low from the cycle after the 40th; LRST=0 and X/Y=(0,0) in the first STREAM cycle; X/Y follow the load order for 40 cycles, then 0.
- Engine model asserts DONE after 100 WAIT cycles with C1=(3,3), C2=(12,12); frame is 20x(3,3), 10x(12,12), 10x(0,15) -> res_score=30, res_cycles=100, res_c1=8'h33, res_c2=8'hCC, res_valid 40 cycles after DONE.
- Boundary frame around C1=(8,8), C2=(0,0): offsets (2,3),(3,2),(4,0),(0,4) covered; (3,3),(4,1),(1,4) not -> score equals the count of covered offsets only.
- TIMEOUT=50 with no DONE -> LRST rises after 50 WAIT cycles, res_timeout=1, res_score=0, res_cycles=50; DONE and timeout on the same cycle -> normal result, res_timeout=0.
- res_ready held low 10 cycles -> outputs stable, in_ready=0; RST pulsed mid-STREAM -> LRST=1 at once, state LOAD, fresh 40-point load required.
